// File: rtl/usb_pkg.sv
// Shared USB receive constants, packet/state types and PID classification.
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        PKT_NONE      = 2'd0,
        PKT_TOKEN     = 2'd1,
        PKT_DATA      = 2'd2,
        PKT_HANDSHAKE = 2'd3
    } pkt_type_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RCV_SYNC  = 4'd1,
        ST_RCV_PID   = 4'd2,
        ST_BODY      = 4'd3,
        ST_CHECK_LEN = 4'd4,
        ST_DONE      = 4'd5,
        ST_ERR_WAIT  = 4'd6,
        ST_ERR_EOP   = 4'd7,
        ST_ERR_IDLE  = 4'd8
    } rx_state_t;

    // PKT_NONE doubles as "invalid PID": bad check nibble or unsupported code.
    function automatic pkt_type_t pid_to_type(input logic [7:0] pid_byte);
        pkt_type_t t;
        t = PKT_NONE;
        if (pid_byte[7:4] == ~pid_byte[3:0]) begin
            case (pid_byte[3:0])
                PID_OUT, PID_IN, PID_SETUP:  t = PKT_TOKEN;
                PID_DATA0, PID_DATA1:        t = PKT_DATA;
                PID_ACK, PID_NAK, PID_STALL: t = PKT_HANDSHAKE;
                default:                     t = PKT_NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/usb_crc_holdback.sv
// Two-byte delay line that withholds the newest two bytes (the CRC16 at packet end).
// A write is issued 1 clk after a shift, only once two older bytes are already held.
module usb_crc_holdback (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       w_enable_o,
    output logic [7:0] w_data_o
);

    logic [7:0] hb0_q;
    logic [7:0] hb1_q;
    logic [1:0] occ_q;
    logic       w_en_q;
    logic [7:0] w_data_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hb0_q    <= '0;
            hb1_q    <= '0;
            occ_q    <= '0;
            w_en_q   <= 1'b0;
            w_data_q <= '0;
        end else begin
            w_en_q <= 1'b0;
            if (clr_i) begin
                hb0_q <= '0;
                hb1_q <= '0;
                occ_q <= '0;
            end else if (shift_i) begin
                hb1_q <= hb0_q;
                hb0_q <= data_i;
                if (occ_q == 2'd2) begin
                    w_en_q   <= 1'b1;
                    w_data_q <= hb1_q;
                end else begin
                    occ_q <= occ_q + 2'd1;
                end
            end
        end
    end

    assign w_enable_o = w_en_q;
    assign w_data_o   = w_data_q;

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive packet FSM: SYNC/PID checks, length rules, error recovery, payload strobes.
// Payload write lands 1 clk after its byte is shifted out of the CRC holdback; no backpressure.
module usb_rx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             eop,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             r_error,
    output logic             w_enable,
    output logic [7:0]       w_data,
    output logic [3:0]       pid,
    output logic [1:0]       pkt_type,
    output logic [CNT_W-1:0] body_count,
    output logic             pkt_done
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LIMIT = CNT_W'(MAX_DATA_BYTES + 2);

    rx_state_t        state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    pkt_type_t        type_q, type_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             eop_qual;
    logic             len_ok;
    logic             hb_clr;
    logic             hb_shift;
    pkt_type_t        rx_type;

    assign eop_qual = eop & shift_enable;
    assign rx_type  = pid_to_type(rcv_data);

    always_comb begin
        len_ok = 1'b0;
        case (type_q)
            PKT_TOKEN:     len_ok = (cnt_q == CNT_TWO);
            PKT_HANDSHAKE: len_ok = (cnt_q == '0);
            PKT_DATA:      len_ok = (cnt_q >= CNT_TWO);
            default:       len_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pid_d    = pid_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hb_clr   = 1'b0;
        hb_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_edge) begin
                    state_d = ST_RCV_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_RCV_SYNC: begin
                if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = ST_RCV_PID;
                        hb_clr  = 1'b1;
                    end else begin
                        state_d = ST_ERR_WAIT;
                    end
                end else if (eop_qual) begin
                    state_d = ST_ERR_WAIT;
                end
            end
            ST_RCV_PID: begin
                if (byte_received) begin
                    if (rx_type != PKT_NONE) begin
                        state_d = ST_BODY;
                        pid_d   = rcv_data[3:0];
                        type_d  = rx_type;
                    end else begin
                        state_d = ST_ERR_WAIT;
                    end
                end else if (eop_qual) begin
                    state_d = ST_ERR_WAIT;
                end
            end
            ST_BODY: begin
                // A byte coinciding with EOP is counted before the EOP is acted on.
                if (byte_received) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (type_q == PKT_DATA) begin
                        if (cnt_q >= DATA_LIMIT) begin
                            state_d = ST_ERR_WAIT;
                        end else begin
                            hb_shift = 1'b1;
                        end
                    end
                end
                if (eop_qual && (state_d == ST_BODY)) begin
                    state_d = ST_CHECK_LEN;
                end
            end
            ST_CHECK_LEN: begin
                if (len_ok) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ERR_IDLE;
                end
            end
            ST_DONE: begin
                if (d_edge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR_WAIT: begin
                if (eop_qual) begin
                    state_d = ST_ERR_EOP;
                end
            end
            ST_ERR_EOP: begin
                if (d_edge) begin
                    state_d = ST_ERR_IDLE;
                end
            end
            ST_ERR_IDLE: begin
                if (d_edge) begin
                    state_d = ST_RCV_SYNC;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            pid_q   <= '0;
            type_q  <= PKT_NONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    usb_crc_holdback u_holdback (
        .clk        (clk),
        .n_rst      (n_rst),
        .clr_i      (hb_clr),
        .shift_i    (hb_shift),
        .data_i     (rcv_data),
        .w_enable_o (w_enable),
        .w_data_o   (w_data)
    );

    assign rcving     = state_q inside {ST_RCV_SYNC, ST_RCV_PID, ST_BODY, ST_CHECK_LEN, ST_ERR_WAIT};
    assign r_error    = state_q inside {ST_ERR_WAIT, ST_ERR_EOP, ST_ERR_IDLE};
    assign pid        = pid_q;
    assign pkt_type   = type_q;
    assign body_count = cnt_q;
    assign pkt_done   = done_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed packet-level bench for usb_rx_ctrl with a rule-based expectation model.
module tb_usb_rx_ctrl;

    localparam int MAXB = 8;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       shift_enable;
    logic       eop;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       r_error;
    logic       w_enable;
    logic [7:0] w_data;
    logic [3:0] pid;
    logic [1:0] pkt_type;
    logic [4:0] body_count;
    logic       pkt_done;

    usb_rx_ctrl #(.MAX_DATA_BYTES(MAXB), .CNT_W(5)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .shift_enable  (shift_enable),
        .eop           (eop),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .r_error       (r_error),
        .w_enable      (w_enable),
        .w_data        (w_data),
        .pid           (pid),
        .pkt_type      (pkt_type),
        .body_count    (body_count),
        .pkt_done      (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;
    int done_seen = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
    } wr_t;
    wr_t wq[$];
    int  done_q[$];

    // Packet-level model state
    logic [7:0] pkt[$];
    logic [3:0] m_pid = 4'h0;
    int         m_type = 0;
    int         m_cnt = 0;
    bit         m_err = 1'b0;
    int         m_ty = 0;
    int         last_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_type(input logic [7:0] b);
        case (b)
            8'hE1, 8'h69, 8'h2D: return 1;
            8'hC3, 8'h4B:        return 2;
            8'hD2, 8'h5A, 8'h1E: return 3;
            default:             return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (n_rst) begin
            if (w_enable) wr_seen++;
            if (pkt_done) done_seen++;
            if (wq.size() > 0 && wq[0].c == cyc) begin
                chk("w_enable", w_enable, 1);
                chk("w_data", w_data, wq[0].d);
                void'(wq.pop_front());
            end else begin
                chk("w_enable_idle", w_enable, 0);
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                chk("pkt_done", pkt_done, 1);
                void'(done_q.pop_front());
            end else begin
                chk("pkt_done_idle", pkt_done, 0);
            end
        end
    end

    task automatic step(input logic de, input logic se, input logic eo,
                        input logic br, input logic [7:0] d);
        @(posedge clk);
        #2;
        d_edge = de; shift_enable = se; eop = eo; byte_received = br; rcv_data = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) idle();
        @(negedge clk);
    endtask

    task automatic start_pkt();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + 1);
        m_cnt = 0;
        chk("start_rcving", rcving, 1);
        chk("start_r_error", r_error, 0);
        chk("start_body_count", body_count, 0);
    endtask

    task automatic push_bytes(input bit eop_last);
        int s;
        s = cyc;
        m_err = 1'b0;
        m_ty = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            if (eop_last && i == pkt.size() - 1) step(1'b0, 1'b1, 1'b1, 1'b1, pkt[i]);
            else                                 step(1'b0, 1'b0, 1'b0, 1'b1, pkt[i]);
            s = cyc + 1;
            if (!m_err) begin
                if (i == 0) begin
                    m_err = (pkt[i] != 8'h80);
                end else if (i == 1) begin
                    m_ty = ref_type(pkt[i]);
                    if (m_ty == 0) m_err = 1'b1;
                    else begin
                        m_pid  = pkt[i][3:0];
                        m_type = m_ty;
                    end
                end else begin
                    if (m_cnt < 31) m_cnt++;
                    if (m_ty == 2) begin
                        if (i - 2 >= MAXB + 2) m_err = 1'b1;
                        else if (i - 2 >= 2) wq.push_back('{c: s, d: pkt[i-2]});
                    end
                end
            end
            wait_until(s);
            chk("r_error_byte", r_error, m_err);
            if (!(eop_last && i == pkt.size() - 1)) chk("rcving_byte", rcving, 1);
        end
        last_s = s;
    endtask

    task automatic finish_pkt(input bit eop_last);
        int e;
        bit pass;
        if (eop_last) e = last_s;
        else begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            e = cyc + 1;
        end
        if (m_err) begin
            wait_until(e);
            chk("r_error_eop", r_error, 1);
            chk("rcving_eop", rcving, 0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            wait_until(cyc + 1);
            chk("r_error_erridle", r_error, 1);
            chk("rcving_erridle", rcving, 0);
        end else begin
            pass = (m_ty == 1 && m_cnt == 2) || (m_ty == 3 && m_cnt == 0) ||
                   (m_ty == 2 && m_cnt >= 2);
            if (pass) done_q.push_back(e + 1);
            wait_until(e + 1);
            chk("r_error_end", r_error, !pass);
            chk("rcving_end", rcving, 0);
            if (pass) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                wait_until(cyc + 1);
                chk("r_error_idle", r_error, 0);
                chk("rcving_idle", rcving, 0);
            end
        end
        chk("pid", pid, m_pid);
        chk("pkt_type", pkt_type, m_type);
        chk("body_count", body_count, m_cnt);
    endtask

    task automatic run(input bit eop_last);
        start_pkt();
        push_bytes(eop_last);
        finish_pkt(eop_last);
    endtask

    int w0;

    initial begin
        n_rst = 1'b0;
        d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
        #1;
        chk("rst_rcving", rcving, 0);
        chk("rst_r_error", r_error, 0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_pkt_type", pkt_type, 0);
        chk("rst_body_count", body_count, 0);
        chk("rst_pkt_done", pkt_done, 0);
        #21;
        n_rst = 1'b1;

        // IN token
        pkt = '{8'h80, 8'h69, 8'h01, 8'h28};
        run(1'b0);
        chk("in_pid_lit", pid, 4'h9);
        chk("in_type_lit", pkt_type, 1);
        chk("in_count_lit", body_count, 2);

        // DATA0 with four payload bytes
        w0 = wr_seen;
        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        run(1'b0);
        chk("data0_writes_lit", wr_seen - w0, 4);
        chk("data0_pid_lit", pid, 4'h3);

        // Bad SYNC
        pkt = '{8'h81, 8'h69};
        run(1'b0);
        chk("badsync_rerr_lit", r_error, 1);

        // Bad PID: previous PID must survive
        pkt = '{8'h80, 8'h6A, 8'h01};
        run(1'b0);
        chk("badpid_pid_lit", pid, 4'h3);
        chk("badpid_type_lit", pkt_type, 2);

        // Oversize DATA1: 11 body bytes
        w0 = wr_seen;
        pkt = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
        run(1'b0);
        chk("oversize_writes_lit", wr_seen - w0, 8);
        chk("oversize_count_lit", body_count, 11);

        // ACK handshake, empty body
        pkt = '{8'h80, 8'hD2};
        run(1'b0);
        chk("ack_type_lit", pkt_type, 3);

        // OUT token with only one body byte
        pkt = '{8'h80, 8'hE1, 8'h05};
        run(1'b0);
        chk("short_token_rerr_lit", r_error, 1);

        // Zero-length DATA1 (CRC only)
        w0 = wr_seen;
        pkt = '{8'h80, 8'h4B, 8'h5A, 8'hA5};
        run(1'b0);
        chk("zlp_writes_lit", wr_seen - w0, 0);

        // Maximum-size DATA0: 8 payload + 2 CRC
        w0 = wr_seen;
        pkt = '{8'h80, 8'hC3, 8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                8'h96, 8'h87, 8'h78, 8'h69};
        run(1'b0);
        chk("max_writes_lit", wr_seen - w0, 8);

        // IN token whose last byte coincides with EOP
        pkt = '{8'h80, 8'h69, 8'h7A, 8'h15};
        run(1'b1);
        chk("eoplast_count_lit", body_count, 2);

        // Counter saturation on an overlong token
        pkt.delete();
        pkt.push_back(8'h80);
        pkt.push_back(8'h69);
        for (int i = 0; i < 33; i++) pkt.push_back(8'(i));
        run(1'b0);
        chk("sat_count_lit", body_count, 31);

        // Reset in the middle of a DATA body, right after a payload write
        start_pkt();
        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33};
        push_bytes(1'b0);
        chk("pre_rst_wen_lit", w_enable, 1);
        #1 n_rst = 1'b0;
        #1;
        chk("midrst_rcving", rcving, 0);
        chk("midrst_r_error", r_error, 0);
        chk("midrst_w_enable", w_enable, 0);
        chk("midrst_w_data", w_data, 0);
        chk("midrst_pid", pid, 0);
        chk("midrst_pkt_type", pkt_type, 0);
        chk("midrst_body_count", body_count, 0);
        chk("midrst_pkt_done", pkt_done, 0);
        wq.delete();
        done_q.delete();
        m_pid = 4'h0; m_type = 0; m_cnt = 0;
        #1 n_rst = 1'b1;

        pkt = '{8'h80, 8'h69, 8'h01, 8'h28};
        run(1'b0);
        chk("post_rst_pid_lit", pid, 4'h9);

        repeat (3) idle();
        chk("done_pulses_lit", done_seen, 7);
        chk("pending_writes", wq.size(), 0);
        chk("pending_done", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
- Receive control unit for the USB packet receiver datapath.
- Consumes decoded-bit and byte events from the NRZI/shift datapath, then runs the packet FSM: SYNC check, PID validation, packet-length rules and error recovery.
- For DATA packets it holds back the trailing two CRC16 bytes, so only payload bytes are written to the downstream encryptor FIFO.

Parameters:
- MAX_DATA_BYTES, 8, maximum payload bytes per DATA packet, excluding CRC16.
- CNT_W, 5, width of the body byte counter; must hold MAX_DATA_BYTES+3.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- d_edge  in  1  one-cycle pulse on any D+ line transition
- shift_enable  in  1  one-cycle pulse at each bit sample point (8 clk per bit)
- eop  in  1  SE0 detected; qualified only when shift_enable=1
- byte_received  in  1  one-cycle pulse: rcv_data holds a complete byte
- rcv_data  in  8  received byte, rcv_data[0] = first bit on wire
- rcving  out  1  packet reception in progress
- r_error  out  1  sticky packet error flag
- w_enable  out  1  one-cycle payload write strobe to FIFO
- w_data  out  8  payload byte, valid with w_enable
- pid  out  4  latched PID[3:0] of current/last packet
- pkt_type  out  2  NONE, TOKEN, DATA or HANDSHAKE
- body_count  out  CNT_W  bytes received after the PID
- pkt_done  out  1  one-cycle pulse: packet accepted without error

Behaviour:
- Reset: all outputs 0, pkt_type=NONE, FSM in IDLE, holdback buffer cleared. Reset mid-packet abandons the packet with no pkt_done or r_error.
- eop_q = eop & shift_enable.
- In BODY, byte_received is processed before eop_q when both occur in the same cycle.

FSM states:
- IDLE: rcving=0. On d_edge go to RCV_SYNC, clear r_error, clear body_count.
- RCV_SYNC: rcving=1.
  - byte_received with rcv_data==8'h80 → RCV_PID.
  - byte_received with any other value → ERR_WAIT.
  - eop_q → ERR_WAIT.
- RCV_PID:
  - On byte_received, the PID is valid when rcv_data[7:4] == ~rcv_data[3:0] and [3:0] is one of OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - Valid PID: latch pid and pkt_type, go to BODY.
  - Invalid PID, or eop_q: go to ERR_WAIT.
- BODY: on byte_received, body_count++.
  - DATA packets only: the 2-deep holdback shifts (hb1←hb0, hb0←rcv_data).
  - If body_count before increment ≥2, the next cycle gives w_enable=1 and w_data=hb1 (old value). Write latency is 1 clk after byte_received.
  - If the DATA body count would exceed MAX_DATA_BYTES+2 → ERR_WAIT immediately.
  - eop_q → CHECK_LEN.
- CHECK_LEN (1 cycle): required body_count is TOKEN ==2, HANDSHAKE ==0, DATA ≥2 (zero-length payload is legal).
  - Pass → DONE, with pkt_done=1 for this one cycle and rcving=0.
  - Fail → ERR_IDLE.
- DONE: wait for d_edge (SE0 to J at end of EOP), then → IDLE.
- ERR_WAIT: r_error=1, rcving=1. On eop_q → ERR_EOP.
- ERR_EOP: r_error=1, rcving=0. On d_edge → ERR_IDLE.
- ERR_IDLE: r_error=1, rcving=0. On d_edge → RCV_SYNC, clear r_error.

Output and datapath rules:
- w_enable never asserts outside BODY-derived writes.
- Payload bytes already written before an error are not retracted; the downstream block discards them on r_error.
- The holdback bytes (the CRC16) are never written.
- body_count saturates at 2^CNT_W-1.
- pid and pkt_type hold their value until the next valid PID.

Decomposition:
- usb_pkg holds:
  - SYNC_BYTE = 8'h80
  - PID_* 4-bit constants
  - pkt_type_t enum {PKT_NONE, PKT_TOKEN, PKT_DATA, PKT_HANDSHAKE}
  - rx_state_t enum
  - the pid_to_type function
- Sub-module usb_crc_holdback: 2-entry byte shift buffer with a write strobe gated on occupancy ≥2; clear input driven on RCV_PID entry.

Test Plan:
- IN token: d_edge, then bytes 8'h80, 8'h69 (PID 1001), 8'h01, 8'h28, then eop_q → pid=4'h9, pkt_type=TOKEN, body_count=2, pkt_done pulse, no w_enable, r_error=0.
- DATA0 with 4 payload bytes: 8'h80, 8'hC3, then bytes 11 22 33 44 AA BB, then eop_q → exactly four w_enable pulses, w_data 11,22,33,44, each 1 clk after its byte_received+2; AA and BB never written; pkt_done=1.
- Bad SYNC: first byte 8'h81 → r_error=1 next clk, no pkt_done. After eop_q and d_edge, rcving=0 and r_error stays 1. The next packet's d_edge clears r_error.
- Bad PID 8'h6A (nibbles not complementary) → ERR_WAIT, r_error=1, pid unchanged from previous packet.
- Oversize DATA: 11 body bytes with MAX_DATA_BYTES=8 → r_error=1 on the 11th byte; 8 writes already issued; no pkt_done.
- ACK handshake (8'hD2), then eop_q with body_count=0 → pkt_done. Separately, TOKEN with 1 body byte → r_error=1.
- Reset asserted mid-BODY → all outputs 0 asynchronously; after reset release, a fresh IN token is received correctly.
